// File: rtl/fp_normalize_round.sv
// Post-add normalise and round-to-nearest-even stage of the single-precision FP adder.
// Build option: define FP_NORM_FTZ_EN to flush subnormal results to signed zero.
module fp_normalize_round #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] mant_sum,
    input  logic        sign_res,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_zero
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    localparam logic [8:0] STEP9 = 9'(SHIFT_STEP);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [24:0] r_m;
    logic [8:0]  r_e;
    logic        r_s;
    logic        r_g;

    logic [8:0]  w_k;
    logic [24:0] w_m_sh;
    logic [8:0]  w_e_sh;
    logic        w_norm_done;

    logic [24:0] w_m_rnd;
    logic [23:0] w_m_fin;
    logic [8:0]  w_e_fin;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_unf;
    logic        w_zero;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction

    // Guard-only ties-to-even: a set guard is an exact half, so round up only if odd.
    function automatic logic [24:0] round_ne(input logic [24:0] m, input logic g);
        round_ne = m + {24'd0, g & m[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_state_nxt = S_NORM;
            S_NORM:  if (w_norm_done) w_state_nxt = S_ROUND;
            S_ROUND:                  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Left-shift amount is capped by the lead-zero count, the per-cycle step and e-1.
    always_comb begin
        w_k = {4'd0, lzc24(r_m[23:0])};
        if (w_k > STEP9)       w_k = STEP9;
        if (w_k > r_e - 9'd1)  w_k = r_e - 9'd1;
        if (r_m == '0 || r_m[24]) w_k = '0;
        w_m_sh      = r_m << w_k;
        w_e_sh      = r_e - w_k;
        w_norm_done = (r_m == '0) || r_m[24] || w_m_sh[23] || (w_e_sh == 9'd1);
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_m <= mant_sum;
                    r_e <= {1'b0, exp_in};
                    r_s <= sign_res;
                    r_g <= 1'b0;
                end
            end
            S_NORM: begin
                if (r_m[24]) begin
                    r_m <= r_m >> 1;
                    r_g <= r_m[0];
                    r_e <= r_e + 9'd1;
                end else begin
                    r_m <= w_m_sh;
                    r_e <= w_e_sh;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_m_rnd = round_ne(r_m, r_g);
        w_m_fin = w_m_rnd[24] ? w_m_rnd[24:1] : w_m_rnd[23:0];
        w_e_fin = w_m_rnd[24] ? r_e + 9'd1 : r_e;
        w_res   = '0;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        w_zero  = 1'b0;
        if (w_m_fin == '0) begin
            w_zero = 1'b1;
        end else if (w_e_fin >= 9'd255) begin
            w_res = {r_s, 8'hFF, 23'h0};
            w_ovf = 1'b1;
        end else if (!w_m_fin[23]) begin
`ifdef FP_NORM_FTZ_EN
            w_res  = {r_s, 31'h0};
            w_unf  = 1'b1;
            w_zero = 1'b1;
`else
            w_res = {r_s, 8'h00, w_m_fin[22:0]};
            w_unf = 1'b1;
`endif
        end else begin
            w_res = {r_s, w_e_fin[7:0], w_m_fin[22:0]};
        end
    end

    // Output registers load on the ROUND->DONE edge and hold through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_zero <= 1'b0;
        end else if (r_state == S_ROUND) begin
            result    <= w_res;
            flag_ovf  <= w_ovf;
            flag_unf  <= w_unf;
            flag_zero <= w_zero;
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: directed cases plus randomized ops against a value-level model.
module tb_fp_normalize_round;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] mant_sum = '0;
    logic        sign_res = 1'b0;
    logic [7:0]  exp_in = 8'd1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        flag_ovf, flag_unf, flag_zero;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          lat;
        int          hs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bp_mode = 0;

    fp_normalize_round #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mant_sum(mant_sum), .sign_res(sign_res), .exp_in(exp_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_zero(flag_zero)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 3) != 0;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Value-level reference: normalise with a plain while loop, then round the guard to even.
    function automatic exp_t model(input logic [24:0] ms, input logic [7:0] ex, input logic s);
        exp_t        r;
        longint      m;
        int          e, g, sh, n;
        logic [23:0] mf;
        logic [7:0]  ef;
        m = longint'(ms); e = int'(ex); g = 0; sh = 0;
        r.res = '0; r.ovf = 0; r.unf = 0; r.zero = 0; r.hs = 0; r.lat = 2;
        if (m == 0) begin
            r.zero = 1;
            return r;
        end
        if (m >= 64'd16777216) begin
            g = int'(m % 2); m = m / 2; e = e + 1;
        end else begin
            while (m < 64'd8388608 && e > 1) begin
                m = m * 2; e = e - 1; sh = sh + 1;
            end
        end
        n = (sh + STEP - 1) / STEP;
        if (n < 1) n = 1;
        r.lat = n + 1;
        if (g == 1 && (m % 2) == 1) m = m + 1;
        if (m == 64'd16777216) begin
            m = m / 2; e = e + 1;
        end
        mf = 24'(m); ef = 8'(e);
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.ovf = 1;
        end else if (m < 64'd8388608) begin
`ifdef FP_NORM_FTZ_EN
            r.res = {s, 31'h0}; r.unf = 1; r.zero = 1;
`else
            r.res = {s, 8'h00, mf[22:0]}; r.unf = 1;
`endif
        end else begin
            r.res = {s, ef, mf[22:0]};
        end
        return r;
    endfunction

    task automatic issue(input logic [24:0] m, input logic [7:0] e, input logic s,
                         input bit use_lit, input exp_t lit, input bit push);
        exp_t x;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        x = use_lit ? lit : model(m, e, s);
        mant_sum = m; exp_in = e; sign_res = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        x.hs = cyc;
        if (push) q.push_back(x);
        in_valid = 1'b0;
        mant_sum = 25'($urandom); exp_in = 8'($urandom); sign_res = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q.size() != 0 || !in_ready); i++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 0);
    endtask

    // Monitor: pops on the first DONE cycle, then checks the output holds while stalled.
    bit          active = 0;
    logic [31:0] held;
    always @(negedge clk) begin
        exp_t cur;
        if (rst) begin
            active = 0;
        end else if (out_valid) begin
            if (!active) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("result", result, cur.res);
                    chk("flag_ovf", flag_ovf, cur.ovf);
                    chk("flag_unf", flag_unf, cur.unf);
                    chk("flag_zero", flag_zero, cur.zero);
                    chk("latency", 64'(cyc - cur.hs), 64'(cur.lat));
                end
                held   = result;
                active = 1;
            end else begin
                chk("stable_result", result, held);
                chk("in_ready_busy", in_ready, 0);
            end
            if (out_ready) active = 0;
        end
    end

    logic [24:0] d_m   [10] = '{25'h0800000, 25'h1000000, 25'h1000003, 25'h1000001, 25'h0000001,
                                25'h0000400, 25'h1FFFFFE, 25'h0000000, 25'h0000000, 25'h0FFFFFF};
    logic [7:0]  d_e   [10] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd3, 8'd254, 8'd100, 8'd50, 8'd1};
    logic        d_s   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef FP_NORM_FTZ_EN
    logic [31:0] d_res [10] = '{32'h3F800000, 32'h40000000, 32'h40000002, 32'h40000000, 32'h34000000,
                                32'h00000000, 32'hFF800000, 32'h00000000, 32'h00000000, 32'h00FFFFFF};
    logic        d_unf [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        d_zero[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
`else
    logic [31:0] d_res [10] = '{32'h3F800000, 32'h40000000, 32'h40000002, 32'h40000000, 32'h34000000,
                                32'h00001000, 32'hFF800000, 32'h00000000, 32'h00000000, 32'h00FFFFFF};
    logic        d_unf [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        d_zero[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
`endif
    logic        d_ovf [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int          d_lat [10] = '{2, 2, 2, 2, 24, 3, 2, 2, 2, 2};

    initial begin
        exp_t        lit;
        logic [24:0] m;
        logic [7:0]  e;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_ovf, flag_unf, flag_zero}, 0);

        for (int i = 0; i < 10; i++) begin
            lit.res = d_res[i]; lit.ovf = d_ovf[i]; lit.unf = d_unf[i];
            lit.zero = d_zero[i]; lit.lat = d_lat[i]; lit.hs = 0;
            issue(d_m[i], d_e[i], d_s[i], 1'b1, lit, 1'b1);
        end
        drain();

        bp_mode = 2;
        issue(25'h0800000, 8'd127, 1'b0, 1'b0, lit, 1'b1);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        chk("stall_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        chk("stall_out_valid_held", out_valid, 1);
        bp_mode = 0;
        drain();

        issue(25'h0000001, 8'd127, 1'b0, 1'b0, lit, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {flag_ovf, flag_unf, flag_zero}, 0);

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom % 4)
                0: m = 25'($urandom);
                1: m = 25'($urandom >> $urandom_range(8, 31));
                2: m = 25'h1000000 | 25'($urandom);
                default: m = 25'h0800000 | 25'($urandom % 32'h800000);
            endcase
            case ($urandom % 3)
                0: e = 8'($urandom_range(1, 254));
                1: e = 8'($urandom_range(1, 24));
                default: e = 8'($urandom_range(250, 254));
            endcase
            issue(m, e, 1'($urandom), 1'b0, lit, 1'b1);
        end
        drain();
        bp_mode = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
